// File: rtl/mirfak_lsu.sv
// Mirfak load/store unit: one Wishbone B4 classic cycle per aligned access,
// with byte-lane selects, store replication, load alignment/extension and kill.
module mirfak_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_address_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [1:0]  lsu_data_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic        lsu_mem_read_i,
  input  logic        lsu_mem_write_i,
  input  logic        lsu_kill_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_ready_o,
  output logic        lsu_bus_error_o,
  output logic        lsu_misaligned_load_o,
  output logic        lsu_misaligned_store_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        killed_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  type_q;
  logic        sign_ext_q;

  logic        misaligned;
  logic [3:0]  sel_d;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        start;
  logic        term;
  logic        silent;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    misaligned = 1'b0;
    sel_d      = 4'b1111;
    wdata_rep  = lsu_wdata_i;
    case (lsu_data_type_i)
      2'b00: begin
        sel_d     = 4'b0001 << lsu_address_i[1:0];
        wdata_rep = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = lsu_address_i[0];
        sel_d      = lsu_address_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{lsu_wdata_i[15:0]}};
      end
      default: misaligned = |lsu_address_i[1:0];
    endcase
  end

  assign lsu_misaligned_load_o  = lsu_mem_read_i  & misaligned;
  assign lsu_misaligned_store_o = lsu_mem_write_i & misaligned;

  // Lane position and width are taken from the captured request, not the live inputs.
  assign shifted = dwbm_dat_i >> {addr_lo_q, 3'b000};
  always_comb begin
    load_data = shifted;
    case (type_q)
      2'b00:   load_data = {{24{sign_ext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{sign_ext_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // A ready pulse blocks a start so the still-held request is not re-issued.
  assign start  = (state_q == IDLE) & (lsu_mem_read_i | lsu_mem_write_i) &
                  ~misaligned & ~lsu_kill_i & ~lsu_ready_o;
  assign term   = (state_q == BUSY) & (dwbm_ack_i | dwbm_err_i);
  assign silent = killed_q | lsu_kill_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (term)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start)
        killed_q <= 1'b0;
      else if (state_q == BUSY && lsu_kill_i)
        killed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwbm_addr_o     <= '0;
      dwbm_dat_o      <= '0;
      dwbm_sel_o      <= '0;
      dwbm_cyc_o      <= 1'b0;
      dwbm_we_o       <= 1'b0;
      lsu_rdata_o     <= '0;
      lsu_ready_o     <= 1'b0;
      lsu_bus_error_o <= 1'b0;
      addr_lo_q       <= '0;
      type_q          <= '0;
      sign_ext_q      <= 1'b0;
    end else begin
      lsu_ready_o     <= 1'b0;
      lsu_bus_error_o <= 1'b0;
      lsu_rdata_o     <= '0;
      if (start) begin
        dwbm_addr_o <= {lsu_address_i[31:2], 2'b00};
        dwbm_dat_o  <= wdata_rep;
        dwbm_sel_o  <= sel_d;
        dwbm_we_o   <= lsu_mem_write_i;
        dwbm_cyc_o  <= 1'b1;
        addr_lo_q   <= lsu_address_i[1:0];
        type_q      <= lsu_data_type_i;
        sign_ext_q  <= lsu_sign_ext_i;
      end
      if (term) begin
        dwbm_cyc_o      <= 1'b0;
        lsu_ready_o     <= ~silent;
        lsu_bus_error_o <= ~silent & dwbm_err_i;
        if (!silent && !dwbm_err_i && !dwbm_we_o)
          lsu_rdata_o <= load_data;
      end
    end
  end

  assign dwbm_stb_o = dwbm_cyc_o;

endmodule
